// File: rtl/signed_count_scheduler.sv
// signed_count_scheduler
// Shares one signed up-counter between two requesters. A round-robin
// pointer breaks ties. The granted requester's start/limit are captured on
// the grant edge. The counter then steps once per clock until it reaches the
// captured limit. Completion is flagged with a one-cycle done pulse.
module signed_count_scheduler #(
  parameter int WIDTH = 4
) (
  input  logic                    C,
  input  logic                    CLR,
  input  logic                    req0,
  input  logic signed [WIDTH-1:0] start0,
  input  logic signed [WIDTH-1:0] lim0,
  input  logic                    req1,
  input  logic signed [WIDTH-1:0] start1,
  input  logic signed [WIDTH-1:0] lim1,
  output logic                    gnt0,
  output logic                    gnt1,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] Q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] STEP = WIDTH'(1);

  state_t r_state;
  state_t w_state_next;

  logic signed [WIDTH-1:0] r_q;
  logic signed [WIDTH-1:0] r_lim;
  logic                    r_gnt0;
  logic                    r_gnt1;
  logic                    r_done;
  logic                    r_pri;

  logic signed [WIDTH-1:0] w_q_next;
  logic signed [WIDTH-1:0] w_lim_next;
  logic                    w_gnt0_next;
  logic                    w_gnt1_next;
  logic                    w_done_next;
  logic                    w_pri_next;

  logic w_any_req;
  logic w_sel;
  logic w_owner_req;
  logic w_at_lim;

  // Winner: the sole requester, or the pointer's favourite when both ask.
  assign w_any_req   = req0 | req1;
  assign w_sel       = (req0 & req1) ? r_pri : req1;
  // Request line of whoever currently owns the counter.
  assign w_owner_req = r_gnt1 ? req1 : req0;
  assign w_at_lim    = (r_q == r_lim);

  // State register, cleared asynchronously.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; an owner dropping its request beats reaching the limit.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_state_next = COUNT;
      COUNT: begin
        if (!w_owner_req)  w_state_next = IDLE;
        else if (w_at_lim) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Next values of grant, counter, limit, pointer and done for each state.
  always_comb begin
    w_q_next    = r_q;
    w_lim_next  = r_lim;
    w_gnt0_next = r_gnt0;
    w_gnt1_next = r_gnt1;
    w_done_next = 1'b0;
    w_pri_next  = r_pri;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_gnt0_next = ~w_sel;
          w_gnt1_next = w_sel;
          w_q_next    = w_sel ? start1 : start0;
          w_lim_next  = w_sel ? lim1 : lim0;
        end
      end
      COUNT: begin
        if (!w_owner_req) begin
          // Abort: release the counter, hold Q, favour the other side next.
          w_gnt0_next = 1'b0;
          w_gnt1_next = 1'b0;
          w_pri_next  = ~r_gnt1;
        end else if (w_at_lim) begin
          w_done_next = 1'b1;
        end else begin
          w_q_next = r_q + STEP;
        end
      end
      DONE: begin
        w_gnt0_next = 1'b0;
        w_gnt1_next = 1'b0;
        w_pri_next  = ~r_gnt1;
      end
      default: begin
        w_gnt0_next = 1'b0;
        w_gnt1_next = 1'b0;
      end
    endcase
  end

  // Datapath and registered outputs, cleared asynchronously.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      r_q    <= '0;
      r_lim  <= '0;
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_done <= 1'b0;
      r_pri  <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_lim  <= w_lim_next;
      r_gnt0 <= w_gnt0_next;
      r_gnt1 <= w_gnt1_next;
      r_done <= w_done_next;
      r_pri  <= w_pri_next;
    end
  end

  assign gnt0 = r_gnt0;
  assign gnt1 = r_gnt1;
  assign done = r_done;
  assign Q    = r_q;
  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_signed_count_scheduler.sv
// Bench for signed_count_scheduler: per-scenario tasks plus a scoreboard of
// expected completions (owner, final Q, cycle of the done pulse).
module tb_signed_count_scheduler;
  localparam int W = 4;

  logic          C = 1'b0;
  logic          CLR;
  logic          req0, req1;
  logic signed [W-1:0] start0, lim0, start1, lim1;
  logic          gnt0, gnt1, busy, done;
  logic signed [W-1:0] Q;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic                owner;
    logic signed [W-1:0] q;
    int                  due;
  } exp_t;
  exp_t exp_q[$];

  signed_count_scheduler #(.WIDTH(W)) dut (
    .C(C), .CLR(CLR),
    .req0(req0), .start0(start0), .lim0(lim0),
    .req1(req1), .start1(start1), .lim1(lim1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .Q(Q)
  );

  always #5 C = ~C;

  always @(posedge C) cyc++;

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(posedge C) begin
    exp_t e;
    #1;
    checks++;
    if (gnt0 === 1'b1 && gnt1 === 1'b1) begin
      failures++;
      $display("FAIL mutex: gnt0=%0b gnt1=%0b at cycle %0d, required not both 1", gnt0, gnt1, cyc);
    end
    if (done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL spurious_done: done=1 at cycle %0d, required no pulse", cyc);
      end else begin
        e = exp_q.pop_front();
        if (gnt0 !== ~e.owner || gnt1 !== e.owner || Q !== e.q || cyc != e.due) begin
          failures++;
          $display("FAIL done_record: gnt1=%0b Q=%0d cycle=%0d, required gnt1=%0b Q=%0d cycle=%0d",
                   gnt1, Q, cyc, e.owner, e.q, e.due);
        end
        $display("done: owner=%0b Q=%0d cycle=%0d", gnt1, Q, cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge C);
    #1;
  endtask

  task automatic test_reset();
    req0 = 1'b0; req1 = 1'b0;
    start0 = '0; lim0 = '0; start1 = '0; lim1 = '0;
    CLR = 1'b0;
    #1 CLR = 1'b1;
    #1;
    checks++;
    if (Q !== 4'sd0 || gnt0 !== 1'b0 || gnt1 !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: Q=%0d gnt=%0b%0b busy=%0b done=%0b, required all 0", Q, gnt1, gnt0, busy, done);
    end
    step();
    checks++;
    if (Q !== 4'sd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_held: Q=%0d busy=%0b, required 0 0", Q, busy);
    end
    #2 CLR = 1'b0;
    step();
    $display("reset: Q=%0d busy=%0b", Q, busy);
  endtask

  task automatic test_single_run();
    logic signed [W-1:0] ev;
    req0 = 1'b1; start0 = -4'sd3; lim0 = 4'sd2;
    exp_q.push_back('{1'b0, 4'sd2, cyc + 7});
    step();
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || Q !== -4'sd3 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_grant: gnt0=%0b gnt1=%0b Q=%0d busy=%0b, required 1 0 -3 1", gnt0, gnt1, Q, busy);
    end
    start0 = 4'sd7; lim0 = -4'sd1;  // must be ignored after the grant edge
    for (int i = 1; i <= 5; i++) begin
      step();
      ev = W'(-3 + i);
      checks++;
      if (Q !== ev || done !== 1'b0 || gnt0 !== 1'b1) begin
        failures++;
        $display("FAIL single_step%0d: Q=%0d done=%0b gnt0=%0b, required Q=%0d done=0 gnt0=1", i, Q, done, gnt0, ev);
      end
    end
    step();
    checks++;
    if (done !== 1'b1 || Q !== 4'sd2 || gnt0 !== 1'b1) begin
      failures++;
      $display("FAIL single_done: done=%0b Q=%0d gnt0=%0b, required 1 2 1", done, Q, gnt0);
    end
    req0 = 1'b0;
    step();
    checks++;
    if (done !== 1'b0 || gnt0 !== 1'b0 || busy !== 1'b0 || Q !== 4'sd2) begin
      failures++;
      $display("FAIL single_release: done=%0b gnt0=%0b busy=%0b Q=%0d, required 0 0 0 2", done, gnt0, busy, Q);
    end
    $display("single_run: complete Q=%0d", Q);
  endtask

  task automatic test_wrap();
    int seq [4] = '{6, 7, -8, -7};
    logic signed [W-1:0] ev;
    req1 = 1'b1; start1 = 4'sd6; lim1 = -4'sd7;
    exp_q.push_back('{1'b1, -4'sd7, cyc + 5});
    for (int i = 0; i < 4; i++) begin
      step();
      ev = W'(seq[i]);
      checks++;
      if (Q !== ev || gnt1 !== 1'b1 || gnt0 !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL wrap_step%0d: Q=%0d gnt1=%0b done=%0b, required Q=%0d gnt1=1 done=0", i, Q, gnt1, done, ev);
      end
    end
    step();
    checks++;
    if (done !== 1'b1 || Q !== -4'sd7) begin
      failures++;
      $display("FAIL wrap_done: done=%0b Q=%0d, required 1 -7", done, Q);
    end
    req1 = 1'b0;
    step();
    checks++;
    if (gnt1 !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL wrap_release: gnt1=%0b busy=%0b, required 0 0", gnt1, busy);
    end
    $display("wrap: complete Q=%0d", Q);
  endtask

  task automatic test_zero();
    req0 = 1'b1; start0 = 4'sd4; lim0 = 4'sd4;
    exp_q.push_back('{1'b0, 4'sd4, cyc + 2});
    step();
    checks++;
    if (Q !== 4'sd4 || gnt0 !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL zero_load: Q=%0d gnt0=%0b done=%0b, required 4 1 0", Q, gnt0, done);
    end
    step();
    checks++;
    if (done !== 1'b1 || Q !== 4'sd4) begin
      failures++;
      $display("FAIL zero_done: done=%0b Q=%0d, required 1 4", done, Q);
    end
    req0 = 1'b0;
    step();
    checks++;
    if (done !== 1'b0 || Q !== 4'sd4 || gnt0 !== 1'b0) begin
      failures++;
      $display("FAIL zero_after: done=%0b Q=%0d gnt0=%0b, required 0 4 0", done, Q, gnt0);
    end
    $display("zero_length: complete Q=%0d", Q);
  endtask

  task automatic test_abort();
    req0 = 1'b1; start0 = 4'sd0; lim0 = 4'sd5;
    step();
    req1 = 1'b1; start1 = -4'sd2; lim1 = -4'sd1;
    step();
    checks++;
    if (Q !== 4'sd1 || gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      failures++;
      $display("FAIL abort_pre: Q=%0d gnt0=%0b gnt1=%0b, required 1 1 0", Q, gnt0, gnt1);
    end
    req0 = 1'b0;
    step();
    checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || Q !== 4'sd1 || done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_edge: gnt=%0b%0b Q=%0d done=%0b busy=%0b, required 00 1 0 0", gnt1, gnt0, Q, done, busy);
    end
    exp_q.push_back('{1'b1, -4'sd1, cyc + 3});
    step();
    checks++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || Q !== -4'sd2) begin
      failures++;
      $display("FAIL abort_next_grant: gnt=%0b%0b Q=%0d, required 10 -2", gnt1, gnt0, Q);
    end
    step();
    step();
    checks++;
    if (done !== 1'b1 || Q !== -4'sd1) begin
      failures++;
      $display("FAIL abort_next_done: done=%0b Q=%0d, required 1 -1", done, Q);
    end
    req1 = 1'b0;
    step();
    // Drop the request on the very edge Q reaches the limit: abort must win.
    req0 = 1'b1; start0 = 4'sd2; lim0 = 4'sd3;
    step();
    step();
    checks++;
    if (Q !== 4'sd3 || done !== 1'b0 || gnt0 !== 1'b1) begin
      failures++;
      $display("FAIL abort_lim_pre: Q=%0d done=%0b gnt0=%0b, required 3 0 1", Q, done, gnt0);
    end
    req0 = 1'b0;
    step();
    checks++;
    if (done !== 1'b0 || gnt0 !== 1'b0 || busy !== 1'b0 || Q !== 4'sd3) begin
      failures++;
      $display("FAIL abort_at_lim: done=%0b gnt0=%0b busy=%0b Q=%0d, required 0 0 0 3", done, gnt0, busy, Q);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL abort_at_lim_late: done=%0b, required 0", done);
    end
    $display("abort: complete Q=%0d", Q);
  endtask

  task automatic test_round_robin();
    int a, last_due, guard, n_grants;
    logic prev_any;
    logic got [8];
    #2 CLR = 1'b1;
    #2 CLR = 1'b0;
    start0 = 4'sd0; lim0 = 4'sd1;
    start1 = 4'b1000; lim1 = -4'sd6;
    req0 = 1'b1; req1 = 1'b1;
    a = cyc + 1;
    for (int r = 0; r < 4; r++) begin
      int n;
      n = (r % 2 == 0) ? 1 : 2;
      exp_q.push_back('{logic'(r % 2), (r % 2 == 0) ? 4'sd1 : -4'sd6, a + n + 1});
      last_due = a + n + 1;
      a = a + n + 3;
    end
    guard = 0; n_grants = 0; prev_any = 1'b0;
    while (cyc < last_due && guard < 60) begin
      step();
      guard++;
      if ((gnt0 | gnt1) && !prev_any && n_grants < 8) begin
        got[n_grants] = gnt1;
        n_grants++;
        $display("round_robin: grant to %0b at cycle %0d", gnt1, cyc);
      end
      prev_any = gnt0 | gnt1;
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (guard >= 60) begin
      failures++;
      $display("FAIL rr_timeout: waited %0d cycles, required done by cycle %0d", guard, last_due);
    end
    checks++;
    if (n_grants != 4) begin
      failures++;
      $display("FAIL rr_grant_count: got %0d grants, required 4", n_grants);
    end
    for (int i = 0; i < n_grants && i < 4; i++) begin
      checks++;
      if (got[i] !== logic'(i % 2)) begin
        failures++;
        $display("FAIL rr_order%0d: owner=%0b, required %0d", i, got[i], i % 2);
      end
    end
    step();
    step();
    checks++;
    if (busy !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      failures++;
      $display("FAIL rr_idle: busy=%0b gnt=%0b%0b, required 0 00", busy, gnt1, gnt0);
    end
  endtask

  task automatic test_reset_mid_run();
    req0 = 1'b1; start0 = -4'sd3; lim0 = 4'sd2;
    step();
    step();
    step();
    #3 CLR = 1'b1;
    #1;
    checks++;
    if (Q !== 4'sd0 || gnt0 !== 1'b0 || gnt1 !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset: Q=%0d gnt=%0b%0b busy=%0b done=%0b, required 0 00 0 0", Q, gnt1, gnt0, busy, done);
    end
    step();
    step();
    checks++;
    if (Q !== 4'sd0 || gnt0 !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrun_hold: Q=%0d gnt0=%0b busy=%0b, required 0 0 0", Q, gnt0, busy);
    end
    req0 = 1'b0;
    #2 CLR = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || Q !== 4'sd0) begin
      failures++;
      $display("FAIL midrun_after: busy=%0b Q=%0d, required 0 0", busy, Q);
    end
    $display("reset_mid_run: Q=%0d busy=%0b", Q, busy);
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_wrap();
    test_zero();
    test_abort();
    test_round_robin();
    test_reset_mid_run();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_done: %0d expected completions missing, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
